// File: rtl/brc_resolve.sv
`default_nettype none
// ============================================================================
// Module   : brc_resolve
// Purpose  : Resolves conditional branches in EX, trains a 16-entry 2-bit BHT,
//            raises a registered redirect on mispredict, counts branches.
// Revision : 1.0 - initial release
// ============================================================================
module brc_resolve (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic        ex_pred_taken,
    input  logic        brc_eq,
    input  logic        brc_lt,
    input  logic        brc_ltu,
    input  logic        stall,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [15:0] branch_cnt,
    output logic [15:0] mispred_cnt
);

    localparam logic [1:0]  c_BHT_INIT = 2'b01;
    localparam logic [1:0]  c_BHT_MAX  = 2'b11;
    localparam logic [1:0]  c_BHT_MIN  = 2'b00;
    localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;
    localparam logic [31:0] c_PC_STEP  = 32'd4;

    logic [1:0]  r_bht [16];
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;
    logic [15:0] r_branch_cnt;
    logic [15:0] r_mispred_cnt;

    logic        w_legal;
    logic        w_cond;
    logic        w_taken;
    logic        w_accept;
    logic        w_mispred;
    logic [3:0]  w_idx;
    logic [1:0]  w_bht_cur;
    logic [1:0]  w_bht_next;
    logic [31:0] w_target;
    logic [31:0] w_fallthrough;

    // funct3[2:1] selects the comparator, funct3[0] inverts the condition.
    assign w_legal = (ex_funct3[2:1] != 2'b01);

    always_comb begin
        w_cond = 1'b0;
        case (ex_funct3[2:1])
            2'b00:   w_cond = brc_eq;
            2'b10:   w_cond = brc_lt;
            2'b11:   w_cond = brc_ltu;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken       = w_cond ^ ex_funct3[0];
    assign w_accept      = ex_valid & ~stall & ~r_redirect_valid & w_legal;
    assign w_mispred     = w_accept & (w_taken != ex_pred_taken);
    assign w_target      = ex_pc + ex_imm;
    assign w_fallthrough = ex_pc + c_PC_STEP;

    assign w_idx     = ex_pc[5:2];
    assign w_bht_cur = r_bht[w_idx];

    always_comb begin
        w_bht_next = w_bht_cur;
        if (w_taken) begin
            if (w_bht_cur != c_BHT_MAX) w_bht_next = w_bht_cur + 2'd1;
        end else begin
            if (w_bht_cur != c_BHT_MIN) w_bht_next = w_bht_cur - 2'd1;
        end
    end

    // Table is read from the registered state, so a same-cycle update is
    // invisible to the lookup until the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bht <= '{default: c_BHT_INIT};
        end else if (w_accept) begin
            r_bht[w_idx] <= w_bht_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
        end else if (r_redirect_valid) begin
            if (!stall) r_redirect_valid <= 1'b0;
        end else if (w_mispred) begin
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= w_taken ? w_target : w_fallthrough;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt  <= 16'd0;
            r_mispred_cnt <= 16'd0;
        end else begin
            if (w_accept && (r_branch_cnt != c_CNT_MAX))
                r_branch_cnt <= r_branch_cnt + 16'd1;
            if (w_mispred && (r_mispred_cnt != c_CNT_MAX))
                r_mispred_cnt <= r_mispred_cnt + 16'd1;
        end
    end

    assign if_pred_taken  = r_bht[if_pc[5:2]][1];
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign branch_cnt     = r_branch_cnt;
    assign mispred_cnt    = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_brc_resolve.sv
`default_nettype none
// ============================================================================
// Module   : tb_brc_resolve
// Purpose  : Self-checking bench for brc_resolve: vector table, directed
//            corner sequences and randomized run against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_brc_resolve;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ex_valid = 1'b0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [31:0] ex_pc = 32'd0;
    logic [31:0] ex_imm = 32'd0;
    logic        ex_pred_taken = 1'b0;
    logic        brc_eq = 1'b0;
    logic        brc_lt = 1'b0;
    logic        brc_ltu = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] if_pc = 32'd0;
    logic        if_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    brc_resolve u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_funct3     (ex_funct3),
        .ex_pc         (ex_pc),
        .ex_imm        (ex_imm),
        .ex_pred_taken (ex_pred_taken),
        .brc_eq        (brc_eq),
        .brc_lt        (brc_lt),
        .brc_ltu       (brc_ltu),
        .stall         (stall),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_bht [16];
    int          m_bcnt;
    int          m_mcnt;
    bit          m_rv;
    logic [31:0] m_rpc;

    task automatic model_reset();
        foreach (m_bht[i]) m_bht[i] = 1;
        m_bcnt = 0;
        m_mcnt = 0;
        m_rv   = 1'b0;
        m_rpc  = 32'd0;
    endtask

    task automatic model_step();
        bit legal, taken, accept;
        int idx;
        legal = !(ex_funct3 == 3'd2 || ex_funct3 == 3'd3);
        case (ex_funct3)
            3'd0: taken = brc_eq;
            3'd1: taken = !brc_eq;
            3'd4: taken = brc_lt;
            3'd5: taken = !brc_lt;
            3'd6: taken = brc_ltu;
            3'd7: taken = !brc_ltu;
            default: taken = 1'b0;
        endcase
        accept = ex_valid && !stall && !m_rv && legal;
        idx = int'(ex_pc[5:2]);
        if (m_rv) begin
            if (!stall) m_rv = 1'b0;
        end else if (accept && (taken != ex_pred_taken)) begin
            m_rv  = 1'b1;
            m_rpc = taken ? (ex_pc + ex_imm) : (ex_pc + 32'd4);
        end
        if (accept) begin
            m_bht[idx] = taken ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                               : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
            if (m_bcnt < 65535) m_bcnt++;
            if (taken != ex_pred_taken && m_mcnt < 65535) m_mcnt++;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0;
        stall    = 1'b0;
    endtask

    task automatic set_br(input logic [2:0] f3, input logic eq, input logic lt,
                          input logic ltu, input logic pred,
                          input logic [31:0] pc, input logic [31:0] imm);
        ex_valid      = 1'b1;
        ex_funct3     = f3;
        brc_eq        = eq;
        brc_lt        = lt;
        brc_ltu       = ltu;
        ex_pred_taken = pred;
        ex_pc         = pc;
        ex_imm        = imm;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic        eq, lt, ltu, pred;
        logic [31:0] pc, imm;
        logic        exp_rv;
        logic [31:0] exp_rpc;
        int          binc, minc;
    } vec_t;

    vec_t tbl [10];
    int   exp_b, exp_m;

    initial begin
        tbl[0] = '{"beq_taken_mp",  3'd0, 1, 0, 0, 0, 32'h100,      32'h20,       1, 32'h120, 1, 1};
        tbl[1] = '{"blt_taken_ok",  3'd4, 0, 1, 0, 1, 32'h300,      32'h10,       0, 32'h0,   1, 0};
        tbl[2] = '{"bne_nt_ok",     3'd1, 1, 0, 0, 0, 32'h340,      32'h40,       0, 32'h0,   1, 0};
        tbl[3] = '{"bne_taken_mp",  3'd1, 0, 0, 0, 0, 32'h400,      32'hFFFFFFF0, 1, 32'h3F0, 1, 1};
        tbl[4] = '{"bge_taken_ok",  3'd5, 0, 0, 1, 1, 32'h480,      32'h80,       0, 32'h0,   1, 0};
        tbl[5] = '{"bltu_nt_mp",    3'd6, 1, 1, 0, 1, 32'h500,      32'h60,       1, 32'h504, 1, 1};
        tbl[6] = '{"illegal_010",   3'd2, 1, 1, 1, 0, 32'h600,      32'h20,       0, 32'h0,   0, 0};
        tbl[7] = '{"illegal_011",   3'd3, 0, 0, 0, 1, 32'h640,      32'h20,       0, 32'h0,   0, 0};
        tbl[8] = '{"wrap_target",   3'd0, 1, 0, 0, 0, 32'hFFFFFFFC, 32'h8,        1, 32'h4,   1, 1};
        tbl[9] = '{"bgeu_nt_mp",    3'd7, 0, 0, 1, 1, 32'h200,      32'h40,       1, 32'h204, 1, 1};

        // asynchronous reset: outputs forced before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rv",    32'(redirect_valid), 32'd0);
        chk("rst_rpc",   redirect_pc,         32'd0);
        chk("rst_bcnt",  32'(branch_cnt),     32'd0);
        chk("rst_mcnt",  32'(mispred_cnt),    32'd0);
        chk("rst_pred",  32'(if_pred_taken),  32'd0);
        do_reset();

        // ---- vector table ----
        exp_b = 0;
        exp_m = 0;
        for (int i = 0; i < 10; i++) begin
            set_br(tbl[i].f3, tbl[i].eq, tbl[i].lt, tbl[i].ltu, tbl[i].pred, tbl[i].pc, tbl[i].imm);
            tick();
            exp_b += tbl[i].binc;
            exp_m += tbl[i].minc;
            chk({tbl[i].name, "_rv"}, 32'(redirect_valid), 32'(tbl[i].exp_rv));
            if (tbl[i].exp_rv) chk({tbl[i].name, "_rpc"}, redirect_pc, tbl[i].exp_rpc);
            chk({tbl[i].name, "_bcnt"}, 32'(branch_cnt), 32'(exp_b));
            chk({tbl[i].name, "_mcnt"}, 32'(mispred_cnt), 32'(exp_m));
            idle();
            tick();
            chk({tbl[i].name, "_clr"}, 32'(redirect_valid), 32'd0);
        end

        // ---- BGEU not-taken drives BHT[0] 01 -> 00 ----
        do_reset();
        if_pc = 32'h0;
        set_br(3'd7, 0, 0, 1, 1, 32'h200, 32'h40);
        tick();
        chk("bgeu_rpc", redirect_pc, 32'h204);
        idle(); tick();
        set_br(3'd0, 1, 0, 0, 0, 32'h0, 32'h8);
        tick(); idle(); tick();
        chk("bht0_after1", 32'(if_pred_taken), 32'd0);
        set_br(3'd0, 1, 0, 0, 0, 32'h0, 32'h8);
        tick(); idle(); tick();
        chk("bht0_after2", 32'(if_pred_taken), 32'd1);

        // ---- three taken at pc 0x10, lookup 0x50 shares index 4 ----
        do_reset();
        if_pc = 32'h50;
        set_br(3'd0, 1, 0, 0, 1, 32'h10, 32'h20);
        #1 chk("bht4_pre_update", 32'(if_pred_taken), 32'd0);
        tick(); chk("bht4_10", 32'(if_pred_taken), 32'd1);
        tick(); chk("bht4_11", 32'(if_pred_taken), 32'd1);
        tick(); chk("bht4_sat", 32'(if_pred_taken), 32'd1);
        set_br(3'd1, 1, 0, 0, 1, 32'h10, 32'h20);
        tick(); chk("bht4_dec", 32'(if_pred_taken), 32'd1);
        chk("bht4_bcnt", 32'(branch_cnt), 32'd4);
        chk("bht4_mcnt", 32'(mispred_cnt), 32'd1);
        idle(); tick();

        // ---- redirect held under stall, wrong-path EX ignored ----
        do_reset();
        set_br(3'd0, 1, 0, 0, 0, 32'h100, 32'h20);
        tick();
        chk("stl_rv0", 32'(redirect_valid), 32'd1);
        stall = 1'b1;
        set_br(3'd0, 1, 0, 0, 0, 32'h700, 32'h44);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stl_rv_hold", 32'(redirect_valid), 32'd1);
            chk("stl_rpc_hold", redirect_pc, 32'h120);
        end
        stall = 1'b0;
        tick();
        chk("stl_rv_clr", 32'(redirect_valid), 32'd0);
        idle(); tick();
        chk("stl_no_extra", 32'(redirect_valid), 32'd0);
        chk("stl_bcnt", 32'(branch_cnt), 32'd1);
        chk("stl_mcnt", 32'(mispred_cnt), 32'd1);

        // ---- reset during a pending redirect ----
        set_br(3'd0, 1, 0, 0, 0, 32'h100, 32'h20);
        tick();
        chk("rstmid_rv", 32'(redirect_valid), 32'd1);
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_rv0",  32'(redirect_valid), 32'd0);
        chk("rstmid_rpc0", redirect_pc,         32'd0);
        chk("rstmid_bcnt", 32'(branch_cnt),     32'd0);
        chk("rstmid_mcnt", 32'(mispred_cnt),    32'd0);
        @(negedge clk);
        model_reset();
        stall = 1'b0;
        set_br(3'd4, 0, 1, 0, 1, 32'h300, 32'h10);
        rst_n = 1'b1;
        tick();
        chk("post_rst_accept", 32'(branch_cnt), 32'd1);
        chk("post_rst_rv", 32'(redirect_valid), 32'd0);
        idle(); tick();
        chk("post_rst_no_rv", 32'(redirect_valid), 32'd0);

        // ---- randomized run against the model ----
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            ex_valid      = ($urandom_range(0, 9) < 7);
            ex_funct3     = 3'($urandom_range(0, 7));
            brc_eq        = 1'($urandom);
            brc_lt        = 1'($urandom);
            brc_ltu       = 1'($urandom);
            ex_pred_taken = 1'($urandom);
            ex_pc         = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFFFFFC)
                                                        : (32'($urandom_range(0, 63)) << 2);
            ex_imm        = $urandom;
            stall         = ($urandom_range(0, 3) == 0);
            if_pc         = 32'($urandom_range(0, 63)) << 2;
            #1;
            chk("rnd_pred", 32'(if_pred_taken), 32'(m_bht[int'(if_pc[5:2])] >= 2));
            tick();
            chk("rnd_rv", 32'(redirect_valid), 32'(m_rv));
            if (m_rv) chk("rnd_rpc", redirect_pc, m_rpc);
            chk("rnd_bcnt", 32'(branch_cnt), 32'(m_bcnt));
            chk("rnd_mcnt", 32'(mispred_cnt), 32'(m_mcnt));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/brc_resolve.md
BRC_RESOLVE -- requirements
Module: brc_resolve

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port ex_valid, input, 1, conditional branch present in EX.
REQ-004 SHALL have port ex_funct3, input, 3, branch type.
REQ-005 SHALL have port ex_pc, input, 32, PC of the EX branch.
REQ-006 SHALL have port ex_imm, input, 32, sign-extended B-immediate.
REQ-007 SHALL have port ex_pred_taken, input, 1, prediction made at fetch for this branch.
REQ-008 SHALL have port brc_eq, input, 1, comparator A==B.
REQ-009 SHALL have port brc_lt, input, 1, signed comparator A<B.
REQ-010 SHALL have port brc_ltu, input, 1, unsigned comparator A<B.
REQ-011 SHALL have port stall, input, 1, pipeline freeze.
REQ-012 SHALL have port if_pc, input, 32, fetch PC for prediction lookup.
REQ-013 SHALL have port if_pred_taken, output, 1, combinational prediction for if_pc.
REQ-014 SHALL have port redirect_valid, output, 1, registered redirect/flush request.
REQ-015 SHALL have port redirect_pc, output, 32, registered corrected fetch PC.
REQ-016 SHALL have port branch_cnt, output, 16, resolved-branch count.
REQ-017 SHALL have port mispred_cnt, output, 16, misprediction count.

Function
REQ-018 SHALL accept a branch in a cycle iff ex_valid=1, stall=0, redirect_valid=0, and ex_funct3 is legal.
REQ-019 SHALL decode taken as follows: 000 eq; 001 !eq; 100 lt; 101 !lt; 110 ltu; 111 !ltu.
REQ-020 SHALL treat funct3 010/011 as illegal: no acceptance, no BHT update, no count, no redirect.
REQ-021 SHALL compute target = ex_pc+ex_imm modulo 2^32 and fallthrough = ex_pc+4 modulo 2^32; carries are discarded.
REQ-022 SHALL flag a mispredict when an accepted branch has taken != ex_pred_taken.
REQ-023 SHALL, on an accepted mispredict, drive redirect_valid=1 on the next cycle, with redirect_pc=target if taken, otherwise fallthrough.
REQ-024 SHALL hold redirect_valid=1 with redirect_pc stable while stall=1, and clear it on the first clock edge with stall=0.
REQ-025 SHALL ignore ex_valid while redirect_valid=1, because the EX instruction is wrong-path.
REQ-026 SHALL keep a 16-entry BHT of 2-bit saturating counters indexed by pc[5:2].
REQ-027 SHALL drive if_pred_taken = BHT[if_pc[5:2]][1], combinational.
REQ-028 SHALL update BHT[ex_pc[5:2]] on acceptance: increment if taken, decrement if not, saturating at 3 and 0.
REQ-029 SHALL return the pre-update counter value on if_pred_taken when the lookup index equals the update index in the same cycle.
REQ-030 SHALL increment branch_cnt on every accepted branch, saturating at 0xFFFF.
REQ-031 SHALL increment mispred_cnt on every accepted mispredict, saturating at 0xFFFF.
REQ-032 SHALL produce exactly one redirect per mispredicted branch; a correct prediction SHALL produce no redirect.

Reset
REQ-033 SHALL, while rst_n=0, force immediately (asynchronously): redirect_valid=0, redirect_pc=0, branch_cnt=0, mispred_cnt=0, all BHT entries=01 (if_pred_taken=0).
REQ-034 SHALL cancel a pending redirect when reset is asserted mid-operation; no redirect SHALL appear after rst_n rises.
REQ-035 SHALL accept branches from the first rising edge after rst_n deasserts.

Verification
REQ-036 Bench SHALL cover BEQ with brc_eq=1, ex_pc=0x100, ex_imm=0x20, pred=0 -> next cycle redirect_valid=1, redirect_pc=0x120, mispred_cnt=1, branch_cnt=1.
REQ-037 Bench SHALL cover BGEU with brc_ltu=1, pc=0x200, pred=1 -> redirect_pc=0x204; BHT[0] decrements from 01 to 00.
REQ-038 Bench SHALL cover BLT with brc_lt=1, pred=1 -> no redirect, branch_cnt+1, mispred_cnt unchanged.
REQ-039 Bench SHALL cover taken branches at pc=0x10 applied three times -> BHT[4] goes 01->10->11->11, and if_pred_taken=1 for if_pc=0x50.
REQ-040 Bench SHALL cover mispredict then stall=1 for 3 cycles -> redirect_valid held 3 cycles with redirect_pc stable; a new ex_valid during redirect is ignored.
REQ-041 Bench SHALL cover ex_pc=0xFFFFFFFC, imm=8, taken, pred=0 -> redirect_pc=0x00000004; also rst_n pulsed low during a pending redirect -> outputs reset and no redirect appears afterwards.
